// File: rtl/apb2axi.sv
// APB target that turns each 32-bit APB transfer into one single-beat 64-bit AXI
// transaction, holding the APB access in wait states until the AXI response returns.
module apb2axi #(
    parameter int               IDWID = 4,
    parameter logic [IDWID-1:0] ID    = '0,
    parameter logic [31:0]      BASE  = 32'h0000_0000,
    parameter logic [31:0]      MASK  = 32'hffff_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [31:0]      paddr,
    input  logic [31:0]      pwdata,
    input  logic [3:0]       pstrb,
    output logic             pready,
    output logic [31:0]      prdata,
    output logic [1:0]       presp,
    output logic             awvalid,
    input  logic             awready,
    output logic [31:0]      awaddr,
    output logic [IDWID-1:0] awid,
    output logic [7:0]       awlen,
    output logic [2:0]       awsize,
    output logic [1:0]       awburst,
    output logic             wvalid,
    input  logic             wready,
    output logic [63:0]      wdata,
    output logic [7:0]       wstrb,
    output logic             wlast,
    input  logic             bvalid,
    output logic             bready,
    input  logic [IDWID-1:0] bid,
    input  logic [1:0]       bresp,
    output logic             arvalid,
    input  logic             arready,
    output logic [31:0]      araddr,
    output logic [IDWID-1:0] arid,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    input  logic             rvalid,
    output logic             rready,
    input  logic [63:0]      rdata,
    input  logic [IDWID-1:0] rid,
    input  logic [1:0]       rresp,
    input  logic             rlast
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RRESP = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [2:0]  state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        miss_q, miss_d;
    logic [1:0]  presp_q, presp_d;
    logic [31:0] prdata_q, prdata_d;

    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic [3:0]  strb_q;

    logic setup;
    logic hit;
    logic lane;
    logic unused_rlast;

    assign setup        = psel && !penable;
    assign hit          = (paddr & MASK) == BASE;
    assign lane         = addr_q[2];
    assign unused_rlast = rlast;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        miss_d    = miss_q;
        presp_d   = presp_q;
        prdata_d  = prdata_q;
        case (state_q)
            S_IDLE: begin
                // A decode miss answers one cycle late so it lands in the access phase.
                if (miss_q) begin
                    miss_d   = 1'b0;
                    presp_d  = RESP_DECERR;
                    prdata_d = '0;
                    state_d  = S_RESP;
                end else if (setup) begin
                    if (!hit) begin
                        miss_d = 1'b1;
                    end else if (pwrite) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_WADDR: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (bvalid) begin
                    presp_d  = (bid != ID) ? RESP_SLVERR : bresp;
                    prdata_d = '0;
                    state_d  = S_RESP;
                end
            end
            S_RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RRESP;
                end
            end
            S_RRESP: begin
                if (rvalid) begin
                    prdata_d = lane ? rdata[63:32] : rdata[31:0];
                    presp_d  = (rid != ID) ? RESP_SLVERR : rresp;
                    state_d  = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            miss_q    <= 1'b0;
            presp_q   <= 2'b00;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            miss_q    <= miss_d;
            presp_q   <= presp_d;
            prdata_q  <= prdata_d;
        end
    end

    // Transfer payload needs no reset: it is only observed while a valid is up.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && setup && !miss_q) begin
            addr_q <= paddr;
            wdat_q <= pwdata;
            strb_q <= pstrb;
        end
    end

    assign pready  = (state_q == S_RESP);
    assign prdata  = prdata_q;
    assign presp   = presp_q;

    assign awvalid = awvalid_q;
    assign awaddr  = {addr_q[31:2], 2'b00};
    assign awid    = ID;
    assign awlen   = 8'd0;
    assign awsize  = 3'd3;
    assign awburst = 2'b01;

    assign wvalid  = wvalid_q;
    assign wdata   = lane ? {wdat_q, 32'h0} : {32'h0, wdat_q};
    assign wstrb   = lane ? {strb_q, 4'h0} : {4'h0, strb_q};
    assign wlast   = 1'b1;

    assign bready  = (state_q == S_WRESP);

    assign arvalid = arvalid_q;
    assign araddr  = {addr_q[31:2], 2'b00};
    assign arid    = ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'd3;
    assign arburst = 2'b01;

    assign rready  = (state_q == S_RRESP);

endmodule
